// File: rtl/disk_pkg.sv
// disk_pkg: shared definitions for the disk block-transfer controller.
//   - FSM state encoding
//   - block geometry (BLOCK_WORDS, IDX_W)
//   - instruction field positions
//   - helper that forms the full backing-store word address
package disk_pkg;

  localparam int BLOCK_WORDS = 128;
  localparam int IDX_W       = 7;
  localparam int OFFSET_W    = 30;
  localparam int FULL_ADDR_W = OFFSET_W + IDX_W;

  // Instruction word layout from the bus slave.
  localparam int INS_WE   = 31;
  localparam int INS_DISK = 30;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    WR_FETCH = 3'd2,
    WR_REQ   = 3'd3,
    DONE     = 3'd4
  } disk_state_e;

  // Untruncated store word address for word idx of the block at offset.
  function automatic logic [FULL_ADDR_W-1:0] block_word_addr(
    input logic [OFFSET_W-1:0] offset,
    input logic [IDX_W-1:0]    idx
  );
    return {offset, idx};
  endfunction

endpackage

// File: rtl/disk_buffer.sv
// disk_buffer: DEPTH x 32 single-port synchronous sector buffer.
// Ports:
//   clk, rst    clock, asynchronous active-low reset (read register only)
//   we_i        write enable; write takes effect at the next rising edge
//   addr_i      word index used for both the write and the read
//   wdata_i     write data
//   rdata_o     registered read data (read-first on a same-address write)
// The storage array is intentionally not reset so block contents survive rst.
module disk_buffer
  import disk_pkg::*;
#(
  parameter int DEPTH = BLOCK_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Registered read port; cleared by reset so the outputs it feeds read zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 32'd0;
    end else begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/disk_ctrl.sv
// disk_ctrl: moves one block between the sector buffer and the backing store.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   instruction         [31] we, [30] disk op, [29:0] block offset
//   write_pause         pulse: copy buffer -> store
//   read_pause          pulse: copy store -> buffer
//   disk_addr           byte address of the bus buffer access (word = [8:2])
//   disk_data_out       bus write data for the buffer
//   disk_data_in        registered buffer read data to the bus
//   disk_operate_done   one-cycle pulse when a block transfer finishes
//   busy                high while a transfer is in progress
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack  backing-store port
module disk_ctrl #(
  parameter int BLOCK_WORDS = disk_pkg::BLOCK_WORDS,
  parameter int MEM_ADDR_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction,
  input  logic                  write_pause,
  input  logic                  read_pause,
  input  logic [8:0]            disk_addr,
  input  logic [31:0]           disk_data_out,
  output logic [31:0]           disk_data_in,
  output logic                  disk_operate_done,
  output logic                  busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
);
  import disk_pkg::*;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = 7'd1;

  disk_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [OFFSET_W-1:0]   offset_q, offset_d;
  // Set for the idle cycle between two store reads of one block.
  logic                  gap_q, gap_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  last_s;
  logic                  buf_we_s;
  logic [IDX_W-1:0]      buf_addr_s;
  logic [31:0]           buf_wdata_s;
  logic [31:0]           buf_rdata_s;
  logic                  unused_s;

  assign last_s   = (idx_q == IDX_LAST);
  assign unused_s = ^disk_addr[1:0];

  // Buffer port mux: the bus owns the buffer in IDLE, idx owns it otherwise.
  always_comb begin
    buf_we_s    = 1'b0;
    buf_addr_s  = idx_q;
    buf_wdata_s = mem_rdata;
    case (state_q)
      IDLE: begin
        buf_addr_s  = disk_addr[8:2];
        buf_wdata_s = disk_data_out;
        buf_we_s    = (instruction[INS_WE:INS_DISK] == 2'b10);
      end
      RD_REQ: begin
        // Capture store data only when our request is the one being acked.
        buf_we_s = mem_req_q & mem_ack;
      end
      default: begin
        buf_we_s = 1'b0;
      end
    endcase
  end

  disk_buffer #(
    .DEPTH (BLOCK_WORDS)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .we_i    (buf_we_s),
    .addr_i  (buf_addr_s),
    .wdata_i (buf_wdata_s),
    .rdata_o (buf_rdata_s)
  );

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    offset_d = offset_q;
    gap_d    = gap_q;
    case (state_q)
      IDLE: begin
        gap_d = 1'b0;
        // A simultaneous write_pause takes priority over read_pause.
        if (write_pause) begin
          offset_d = instruction[OFFSET_W-1:0];
          idx_d    = 7'd0;
          state_d  = WR_FETCH;
        end else if (read_pause) begin
          offset_d = instruction[OFFSET_W-1:0];
          idx_d    = 7'd0;
          state_d  = RD_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (mem_ack) begin
          if (last_s) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_ONE;
            gap_d = 1'b1;
          end
        end else begin
          gap_d = 1'b0;
        end
      end
      WR_FETCH: begin
        state_d = WR_REQ;
      end
      WR_REQ: begin
        if (mem_ack) begin
          if (last_s) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = WR_FETCH;
          end
        end else begin
          state_d = WR_REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = 7'd0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 7'd0;
        gap_d   = 1'b0;
      end
    endcase

    // Outputs are computed from the next state so they are registered yet
    // line up with the state they belong to.
    mem_req_d  = ((state_d == RD_REQ) && !gap_d) || (state_d == WR_REQ);
    mem_we_d   = (state_d == WR_REQ);
    mem_addr_d = MEM_ADDR_W'(block_word_addr(offset_d, idx_d));
    busy_d     = (state_d != IDLE);
    done_d     = (state_q == DONE);
  end

  // State, transfer position and registered output flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= 7'd0;
      offset_q   <= 30'd0;
      gap_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= {MEM_ADDR_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      offset_q   <= offset_d;
      gap_q      <= gap_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // The buffer read register doubles as the write-data latch: in WR_REQ it
  // keeps reading idx, so the value is stable for the whole request.
  assign disk_data_in      = buf_rdata_s;
  assign mem_wdata         = buf_rdata_s;
  assign mem_req           = mem_req_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign busy              = busy_q;
  assign disk_operate_done = done_q;

endmodule

// File: tb/tb_disk_ctrl.sv
module tb_disk_ctrl;
  localparam int NW     = 128;
  localparam int BUDGET = 2500;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        write_pause;
  logic        read_pause;
  logic [8:0]  disk_addr;
  logic [31:0] disk_data_out;
  logic [31:0] disk_data_in;
  logic        disk_operate_done;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_buf [NW];
  logic [31:0] rd_key;
  int          stall_max;

  logic [31:0] log_addr [$];
  logic        log_we [$];
  logic [31:0] log_wdata [$];

  disk_ctrl #(.BLOCK_WORDS(128), .MEM_ADDR_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .instruction       (instruction),
    .write_pause       (write_pause),
    .read_pause        (read_pause),
    .disk_addr         (disk_addr),
    .disk_data_out     (disk_data_out),
    .disk_data_in      (disk_data_in),
    .disk_operate_done (disk_operate_done),
    .busy              (busy),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_ack           (mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Store contents: a keyed function of the word address.
  function automatic logic [31:0] store_val(input logic [31:0] a);
    return a ^ rd_key;
  endfunction

  // Word address of word i of block 'off' = off*128 + i, kept to 32 bits.
  function automatic logic [31:0] blk_addr(input logic [29:0] off, input int i);
    logic [63:0] full;
    full = {34'd0, off} * 64'd128 + 64'(i);
    return full[31:0];
  endfunction

  // Backing-store model with random wait states and a transaction log.
  initial begin : store_model
    bit          in_req;
    int          stall_left;
    logic [31:0] cap_addr;
    logic        cap_we;
    logic [31:0] cap_wdata;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    in_req    = 1'b0;
    stall_left = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_ack = 1'b0;
        in_req  = 1'b0;
      end else if (mem_req) begin
        if (!in_req) begin
          in_req     = 1'b1;
          cap_addr   = mem_addr;
          cap_we     = mem_we;
          cap_wdata  = mem_wdata;
          stall_left = $urandom_range(0, stall_max);
        end else begin
          check("hold_addr", mem_addr, cap_addr);
          check("hold_we", mem_we, cap_we);
          if (cap_we) check("hold_wdata", mem_wdata, cap_wdata);
        end
        if (stall_left == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = cap_we ? $urandom : store_val(cap_addr);
          log_addr.push_back(cap_addr);
          log_we.push_back(cap_we);
          log_wdata.push_back(cap_wdata);
          in_req = 1'b0;
        end else begin
          stall_left--;
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        mem_ack = 1'b0;
        in_req  = 1'b0;
      end
    end
  end

  task automatic bus_write(input int idx, input logic [31:0] d);
    logic [6:0] w;
    w = idx[6:0];
    @(negedge clk);
    instruction   = 32'h8000_0000;
    disk_addr     = {w, 2'b00};
    disk_data_out = d;
    @(negedge clk);
    instruction = 32'h0;
  endtask

  task automatic bus_read(input int idx, output logic [31:0] d);
    logic [6:0] w;
    w = idx[6:0];
    @(negedge clk);
    instruction = 32'h0;
    disk_addr   = {w, 2'b00};
    @(negedge clk);
    d = disk_data_in;
  endtask

  task automatic check_buffer(input string tag);
    logic [31:0] d;
    for (int i = 0; i < NW; i++) begin
      bus_read(i, d);
      check($sformatf("%s[%0d]", tag, i), d, model_buf[i]);
    end
  endtask

  // One block transfer. wr/rd select the pauses; a write wins when both are set.
  // inject_at: cycle of a stray read_pause plus bus write; reset_at: cycle of rst.
  task automatic run_xfer(input logic wr, input logic rd, input logic [29:0] off,
                          input int max_stall, input int inject_at, input int reset_at);
    int          n, done_n, done_cnt, first_req, nwords, nchk;
    bit          fin, aborted;
    logic [31:0] a;
    log_addr.delete();
    log_we.delete();
    log_wdata.delete();
    stall_max = max_stall;
    @(negedge clk);
    instruction = {2'b01, off};
    write_pause = wr;
    read_pause  = rd;
    n = 0; done_n = 0; done_cnt = 0; first_req = 0; fin = 1'b0; aborted = 1'b0;
    while (!fin && n < BUDGET) begin
      @(negedge clk);
      n++;
      write_pause = 1'b0;
      read_pause  = 1'b0;
      instruction = 32'h0;
      if (n == 1) check("busy_rise", busy, 1);
      if (mem_req && first_req == 0) first_req = n;
      if (disk_operate_done) begin
        done_cnt++;
        if (done_n == 0) begin
          done_n = n;
          check("busy_fall", busy, 0);
        end
      end
      if (n == inject_at) begin
        read_pause    = 1'b1;
        instruction   = 32'h8000_0000;
        disk_addr     = 9'h004;
        disk_data_out = $urandom;
      end
      if (n == reset_at) begin
        rst = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_data_in", disk_data_in, 0);
        check("rst_done", disk_operate_done, 0);
        check("rst_busy", busy, 0);
        aborted = 1'b1;
        fin     = 1'b1;
      end else if (done_n != 0 && n == done_n + 4) begin
        check("quiet_after_done", {busy, mem_req}, 0);
        fin = 1'b1;
      end
    end
    if (aborted) begin
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("no_stale_req", mem_req, 0);
      end
      nwords = reset_at / 2;
      check("abort_words", log_addr.size(), nwords);
    end else begin
      check("done_seen", done_n != 0, 1);
      check("done_width", done_cnt, 1);
      if (max_stall == 0) begin
        check("done_lat", done_n, wr ? 258 : 257);
        check("first_req", first_req, wr ? 2 : 1);
      end
      nwords = NW;
      check("word_count", log_addr.size(), NW);
    end
    nchk = (log_addr.size() < nwords) ? log_addr.size() : nwords;
    for (int i = 0; i < nchk; i++) begin
      a = blk_addr(off, i);
      check($sformatf("addr[%0d]", i), log_addr[i], a);
      check($sformatf("dir[%0d]", i), log_we[i], wr);
      if (wr) check($sformatf("wdata[%0d]", i), log_wdata[i], model_buf[i]);
    end
    if (!wr) begin
      for (int i = 0; i < nwords; i++) model_buf[i] = store_val(blk_addr(off, i));
    end
  endtask

  initial begin : main
    logic [31:0] d;
    logic [31:0] v;
    logic [29:0] off;
    rst = 1'b0;
    instruction = 32'h0;
    write_pause = 1'b0;
    read_pause = 1'b0;
    disk_addr = 9'h0;
    disk_data_out = 32'h0;
    rd_key = 32'h0;
    stall_max = 0;
    repeat (3) @(negedge clk);
    check("reset_data_in", disk_data_in, 0);
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_wdata", mem_wdata, 0);
    check("reset_busy", busy, 0);
    check("reset_done", disk_operate_done, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NW; i++) begin
      v = $urandom;
      bus_write(i, v);
      model_buf[i] = v;
    end
    bus_write(127, 32'hDEAD_BEEF);
    model_buf[127] = 32'hDEAD_BEEF;
    bus_read(127, d);
    check("bus_rd_1fc", d, 32'hDEAD_BEEF);
    bus_read(0, d);
    check("bus_word0", d, model_buf[0]);
    bus_write(5, 32'h1234_5678);
    bus_write(5, 32'h1234_5678);
    model_buf[5] = 32'h1234_5678;
    bus_read(5, d);
    check("bus_idem", d, 32'h1234_5678);

    // Read block at offset 5 from a store that returns its own address.
    rd_key = 32'h0;
    run_xfer(1'b0, 1'b1, 30'd5, 0, 0, 0);
    check_buffer("rd5");

    // Write block at offset 3 after filling buffer[i] = ~i.
    for (int i = 0; i < NW; i++) begin
      v = ~32'(i);
      bus_write(i, v);
      model_buf[i] = v;
    end
    run_xfer(1'b1, 1'b0, 30'd3, 0, 0, 0);

    // Random offsets and stalls: read, write, both pauses (write wins), read.
    for (int k = 0; k < 4; k++) begin
      rd_key = $urandom;
      off    = 30'($urandom);
      case (k)
        0:       run_xfer(1'b0, 1'b1, off, 5, 0, 0);
        1:       run_xfer(1'b1, 1'b0, off, 5, 0, 0);
        2:       run_xfer(1'b1, 1'b1, off, 5, 0, 0);
        default: run_xfer(1'b0, 1'b1, off, 5, 0, 0);
      endcase
      if (k == 0 || k == 3) check_buffer($sformatf("rnd%0d", k));
    end

    // Stray read_pause and bus write mid-transfer are ignored.
    rd_key = $urandom;
    off    = 30'($urandom);
    run_xfer(1'b0, 1'b1, off, 0, 60, 0);
    check_buffer("inject");

    // Reset during word 60 of a read, then a clean read.
    rd_key = $urandom;
    off    = 30'($urandom);
    run_xfer(1'b0, 1'b1, off, 0, 0, 120);
    check_buffer("after_rst");
    rd_key = $urandom;
    off    = 30'($urandom);
    run_xfer(1'b0, 1'b1, off, 0, 0, 0);
    check_buffer("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
